// File: rtl/cache_comp.sv
// Tag compare and miss handling for a 2-way cache: answers hits directly and refills a line from memory on a miss.
// Optional hit/miss statistics counters are enabled with `define CACHE_STAT_EN.
module cache_comp #(
  parameter int TAG_W      = 20,
  parameter int IDX_W      = 7,
  parameter int LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     comp_in_en,
  input  logic                     valid1_in,
  input  logic                     valid2_in,
  input  logic [TAG_W-1:0]         tag1_in,
  input  logic [TAG_W-1:0]         tag2_in,
  input  logic [31:0]              data1_in,
  input  logic [31:0]              data2_in,
  input  logic [31:0]              cpu_addr_in,
  output logic                     stall,
  output logic                     cpu_data_ok,
  output logic [31:0]              cpu_data_out,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     write_en,
  output logic [31:0]              write_addr,
  output logic [LINE_WORDS*32-1:0] write_data,
  input  logic                     write_ok
`ifdef CACHE_STAT_EN
  ,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
`endif
);

  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int LINE_LSB = 32 - TAG_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_RECV, FILL, WAIT_OK, RESP} state_t;

  state_t                         state_q, state_d;
  logic [31:2]                    addr_q, addr_d;
  logic [OFF_W-1:0]               cnt_q, cnt_d;
  logic [LINE_WORDS-1:0][31:0]    line_q, line_d;
  logic                           stall_q, stall_d;
  logic                           ok_q, ok_d;
  logic [31:0]                    data_q, data_d;
  logic                           req_q, req_d;
  logic                           wen_q, wen_d;

  logic hit1, hit2, hit;
  logic unused_addr_lsb;

  assign hit1 = valid1_in && (tag1_in == cpu_addr_in[31:32-TAG_W]);
  assign hit2 = valid2_in && (tag2_in == cpu_addr_in[31:32-TAG_W]);
  assign hit  = hit1 || hit2;
  assign unused_addr_lsb = ^cpu_addr_in[1:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    ok_d    = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (comp_in_en) begin
          if (hit) begin
            ok_d   = 1'b1;
            data_d = hit1 ? data1_in : data2_in;
          end else begin
            addr_d  = cpu_addr_in[31:2];
            state_d = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = MEM_RECV;
        end
      end
      MEM_RECV: begin
        if (mem_rvalid) begin
          line_d[cnt_q] = mem_rdata;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = FILL;
        end
      end
      FILL:    state_d = WAIT_OK;
      WAIT_OK: if (write_ok) state_d = RESP;
      RESP: begin
        ok_d    = 1'b1;
        data_d  = line_q[addr_q[LINE_LSB-1:2]];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Control outputs follow the next state so they line up with the registered state.
    stall_d = (state_d != IDLE);
    req_d   = (state_d == MEM_REQ);
    wen_d   = (state_d == FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      stall_q <= 1'b0;
      ok_q    <= 1'b0;
      data_q  <= '0;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      stall_q <= stall_d;
      ok_q    <= ok_d;
      data_q  <= data_d;
      req_q   <= req_d;
      wen_q   <= wen_d;
    end
  end

  assign stall        = stall_q;
  assign cpu_data_ok  = ok_q;
  assign cpu_data_out = data_q;
  assign mem_req      = req_q;
  assign mem_addr     = {addr_q[31:LINE_LSB], {LINE_LSB{1'b0}}};
  assign write_en     = wen_q;
  assign write_addr   = {addr_q[31:LINE_LSB], {LINE_LSB{1'b0}}};
  assign write_data   = line_q;

`ifdef CACHE_STAT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && comp_in_en) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_comp.sv
// Directed bench for cache_comp: hits, way priority, refill, stall behaviour and reset mid-refill.
module tb_cache_comp;
  logic         clk, rst, comp_in_en, valid1_in, valid2_in;
  logic [19:0]  tag1_in, tag2_in;
  logic [31:0]  data1_in, data2_in, cpu_addr_in;
  logic         stall, cpu_data_ok, mem_req, mem_ready, mem_rvalid, write_en, write_ok;
  logic [31:0]  cpu_data_out, mem_addr, mem_rdata, write_addr;
  logic [255:0] write_data;
`ifdef CACHE_STAT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int wen_seen = 0;
  logic [255:0] exp_line;

  cache_comp dut (
    .clk(clk), .rst(rst), .comp_in_en(comp_in_en),
    .valid1_in(valid1_in), .valid2_in(valid2_in),
    .tag1_in(tag1_in), .tag2_in(tag2_in),
    .data1_in(data1_in), .data2_in(data2_in), .cpu_addr_in(cpu_addr_in),
    .stall(stall), .cpu_data_ok(cpu_data_ok), .cpu_data_out(cpu_data_out),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .write_ok(write_ok)
`ifdef CACHE_STAT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (write_en) wen_seen++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".stall"}, stall, 0);
    chk({tag, ".ok"}, cpu_data_ok, 0);
    chk({tag, ".data"}, cpu_data_out, 0);
    chk({tag, ".mem_req"}, mem_req, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".write_en"}, write_en, 0);
    chk({tag, ".write_addr"}, write_addr, 0);
    chk({tag, ".write_data"}, write_data, 0);
  endtask

  initial begin
    rst = 1'b1; comp_in_en = 0; valid1_in = 0; valid2_in = 0;
    tag1_in = 0; tag2_in = 0; data1_in = 0; data2_in = 0; cpu_addr_in = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; write_ok = 0;
    tick; tick;
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick;

    // Hit on way 1 only
    valid1_in = 1; tag1_in = 20'h12345; data1_in = 32'hDEAD_BEEF;
    valid2_in = 0; tag2_in = 20'h12345; data2_in = 32'h1111_1111;
    cpu_addr_in = 32'h1234_50A4; comp_in_en = 1;
    tick; comp_in_en = 0;
    chk("hit1.ok", cpu_data_ok, 1);
    chk("hit1.data", cpu_data_out, 32'hDEAD_BEEF);
    chk("hit1.stall", stall, 0);
    tick;
    chk("hit1.ok_pulse", cpu_data_ok, 0);

    // Hit on way 2 only (way 1 tag differs)
    valid1_in = 1; tag1_in = 20'h00ABD; valid2_in = 1; tag2_in = 20'h00ABC;
    data2_in = 32'h2222_2222; cpu_addr_in = 32'h00AB_C010; comp_in_en = 1;
    tick; comp_in_en = 0;
    chk("hit2.ok", cpu_data_ok, 1);
    chk("hit2.data", cpu_data_out, 32'h2222_2222);

    // Both ways hit: way 1 wins
    tag1_in = 20'h12345; tag2_in = 20'h12345;
    data1_in = 32'hAAAA_AAAA; data2_in = 32'hBBBB_BBBB;
    cpu_addr_in = 32'h1234_50A4; comp_in_en = 1;
    tick; comp_in_en = 0;
    chk("both.ok", cpu_data_ok, 1);
    chk("both.data", cpu_data_out, 32'hAAAA_AAAA);
    tick;

    // Miss: tag matches way 1 but valid is low
    valid1_in = 0; valid2_in = 0; tag1_in = 20'h00001;
    cpu_addr_in = 32'h0000_1014; comp_in_en = 1;
    tick; comp_in_en = 0;
    chk("miss.ok", cpu_data_ok, 0);
    chk("miss.stall", stall, 1);
    chk("miss.mem_req", mem_req, 1);
    chk("miss.mem_addr", mem_addr, 32'h0000_1000);
    mem_rvalid = 1; mem_rdata = 32'hBAD0_0BAD;  // stray beat before grant
    tick; mem_rvalid = 0;
    chk("miss.req_held", mem_req, 1);
    mem_ready = 1;
    tick; mem_ready = 0;
    chk("miss.req_drop", mem_req, 0);
    chk("miss.stall_recv", stall, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        mem_rvalid = 0;
        tick;
      end
      mem_rvalid = 1; mem_rdata = 32'h100 + i;
      // Requests arriving while stalled must be ignored
      comp_in_en = (i == 2 || i == 5); valid1_in = 1; cpu_addr_in = 32'h0000_1000;
      tick;
      comp_in_en = 0;
      if (i < 7) chk("recv.no_wen", write_en, 0);
      if (i == 2 || i == 5) chk("stall.no_ok", cpu_data_ok, 0);
    end
    mem_rvalid = 0; valid1_in = 0;
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h100 + i;
    chk("fill.write_en", write_en, 1);
    chk("fill.word1", write_data[63:32], 32'h101);
    chk("fill.line", write_data, exp_line);
    chk("fill.write_addr", write_addr, 32'h0000_1000);
    chk("stall.no_req", mem_req, 0);
    tick;
    chk("fill.wen_pulse", write_en, 0);
    tick;
    chk("waitok.ok", cpu_data_ok, 0);
    chk("waitok.stall", stall, 1);
    write_ok = 1;
    tick; write_ok = 0;
    chk("resp.stall", stall, 1);
    tick;
    chk("resp.ok", cpu_data_ok, 1);
    chk("resp.data", cpu_data_out, 32'h105);
    chk("resp.stall_drop", stall, 0);
    tick;
    chk("resp.ok_pulse", cpu_data_ok, 0);
    chk("refill1.wen_count", wen_seen, 1);

    // Second miss, reset after 4 beats
    cpu_addr_in = 32'h0002_0038; comp_in_en = 1;
    tick; comp_in_en = 0;
    mem_ready = 1;
    tick; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1; mem_rdata = 32'h200 + i;
      tick;
    end
    mem_rvalid = 0;
`ifdef CACHE_STAT_EN
    chk("stat.hit", hit_cnt, 3);
    chk("stat.miss", miss_cnt, 2);
`endif
    rst = 1;
    #1;
    chk_idle_outputs("midreset");
`ifdef CACHE_STAT_EN
    chk("stat.hit_rst", hit_cnt, 0);
    chk("stat.miss_rst", miss_cnt, 0);
`endif
    tick;
    rst = 0;
    tick; tick;
    chk("midreset.idle_stall", stall, 0);
    chk("midreset.no_wen", wen_seen, 1);

    // Fresh miss after reset, requesting the top word of the line
    cpu_addr_in = 32'h0003_005C; comp_in_en = 1;
    tick; comp_in_en = 0;
    chk("fresh.mem_req", mem_req, 1);
    chk("fresh.mem_addr", mem_addr, 32'h0003_0040);
    mem_ready = 1;
    tick; mem_ready = 0;
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = 1; mem_rdata = 32'h300 + i;
      tick;
    end
    mem_rvalid = 0;
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h300 + i;
    chk("fresh.write_en", write_en, 1);
    chk("fresh.line", write_data, exp_line);
    chk("fresh.write_addr", write_addr, 32'h0003_0040);
    tick;
    write_ok = 1;
    tick; write_ok = 0;
    tick;
    chk("fresh.ok", cpu_data_ok, 1);
    chk("fresh.data", cpu_data_out, 32'h307);
    chk("fresh.wen_count", wen_seen, 2);
`ifdef CACHE_STAT_EN
    chk("stat.miss_fresh", miss_cnt, 1);
`endif
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
